// File: rtl/fp_pkg.sv
// FP32 field widths, exponent bias and the packed result layout shared by the
// integer-to-float converter.
package fp_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/findFirstOne32.sv
// Priority encoder: position of the most significant set bit of a 32-bit word.
// Combinational; an all-zero input reports position 0 (callers detect zero themselves).
module findFirstOne32 (
  input  logic [31:0] i_vec,
  output logic [4:0]  o_pos
);

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_vec[i]) o_pos = 5'(i);
    end
  end

endmodule

// File: rtl/int32_to_fp32.sv
// Signed int32 -> IEEE-754 single, two register stages (sign/magnitude, then normalise).
// Truncates toward zero by default; INT32_TO_FP32_ROUND_NEAREST_EN selects round-to-nearest-even.
module int32_to_fp32
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic        r_s1_vld;
  logic        r_s1_sign;
  logic [31:0] r_s1_mag;
  logic        r_s2_vld;
  fp32_t       r_s2_res;

  logic        w_s2_adv;
  logic [4:0]  w_pos;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_carry;
  fp32_t       w_res;

  // Outputs are forced quiet while reset is held, not only after the edge.
  assign out_valid = r_s2_vld & ~rst;
  assign out_data  = r_s2_res;
  assign w_s2_adv  = ~out_valid | out_ready;
  assign in_ready  = ~rst & (~r_s1_vld | w_s2_adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else if (in_ready) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_data[31];
        r_s1_mag  <= in_data[31] ? (~in_data + 32'd1) : in_data;
      end
    end
  end

  findFirstOne32 u_ffo (
    .i_vec (r_s1_mag),
    .o_pos (w_pos)
  );

  assign w_exp = 8'(FP32_BIAS) + {3'd0, w_pos};

`ifdef INT32_TO_FP32_ROUND_NEAREST_EN
  logic [30:0] w_frac;
  logic        w_inc;

  // Leading one shifted off the top; bit 7 is guard, bits 6:0 form sticky.
  assign w_frac = 31'(r_s1_mag << (5'd31 - w_pos));
  assign w_inc  = w_frac[7] & ((|w_frac[6:0]) | w_frac[8]);
  assign {w_carry, w_man} = {1'b0, w_frac[30:8]} + {23'd0, w_inc};
`else
  assign w_man   = 23'((r_s1_mag << (5'd31 - w_pos)) >> 8);
  assign w_carry = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    if (r_s1_mag != 32'd0) begin
      w_res.sign = r_s1_sign;
      w_res.exp  = w_exp + {7'd0, w_carry};
      w_res.man  = w_man;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_s2_res <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2_res <= w_res;
    end
  end

endmodule
